// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifq_pkg
//  Purpose  : Shared types and constants for the instruction fetch queue.
//             - ifq_state_t : fetch FSM state encoding
//             - ifq_entry_t : one buffered instruction with its PC
//             - NOP_INSTR   : word presented on ir when nothing is valid
//  Revision : 1.0 - initial release
// ============================================================================
package ifq_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    KILL     = 2'd2
  } ifq_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ifq_fifo
//  Purpose  : Synchronous FIFO of ifq_entry_t. Output is the registered head
//             entry, so a push is visible on data_o one cycle later.
//  Ports    : CLK, RST      - clock, synchronous active-high reset
//             push_i/data_i - write one entry (caller guarantees not full)
//             pop_i         - drop the head entry (caller guarantees not empty)
//             flush_i       - empty the FIFO; wins over push and pop
//             data_o        - head entry
//             count_o       - number of stored entries (0..DEPTH)
//             empty_o       - count_o == 0
//  Revision : 1.0 - initial release
// ============================================================================
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push_i,
  input  ifq_entry_t               data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output ifq_entry_t               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge CLK) begin
    if (RST || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (push_i && !pop_i) begin
        count_q <= count_q + CW'(1);
      end else if (pop_i && !push_i) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Fetch stage in front of decode. Owns the fetch PC, issues one
//             outstanding word read to instruction memory, buffers returned
//             words with their PCs and hands them to decode over valid/ready.
//             A redirect flushes the queue and restarts fetch.
//  Ports    : CLK, RST                       - clock, sync active-high reset
//             imem_req/imem_addr/imem_gnt     - request channel
//             imem_rvalid/imem_rdata          - response channel
//             redirect_valid/redirect_pc      - branch/jump restart
//             ir_valid/ir_ready/ir/ir_pc      - decode handshake
//  Macro    : IFQ_BYPASS_EN - when defined, a response arriving with the
//             queue empty is presented to decode in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  ifq_entry_t    fifo_head;
  logic          fifo_push;
  logic          fifo_pop;

  logic w_inflight;
  logic w_grant;
  logic w_rsp_ok;

  // Only a response that WAIT_RSP is waiting for counts against space;
  // a KILL response is discarded and never lands in the FIFO.
  assign w_inflight = (state_q == WAIT_RSP);
  assign imem_req   = (state_q == FETCH) && !RST &&
                      ((fifo_count + CW'(w_inflight)) < CW'(DEPTH));
  assign imem_addr  = fetch_pc_q;
  assign w_grant    = imem_req && imem_gnt;
  assign w_rsp_ok   = (state_q == WAIT_RSP) && imem_rvalid && !redirect_valid;

  // --------------------------------------------------------------------------
  // FSM and PC next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;

    if (w_grant) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    unique case (state_q)
      FETCH: begin
        // A request granted in the redirect cycle is for the old path.
        if (w_grant) state_d = redirect_valid ? KILL : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rvalid)         state_d = FETCH;
        else if (redirect_valid) state_d = KILL;
      end
      KILL: begin
        // The stale response retires the outstanding request; a redirect
        // arriving alongside it has already updated fetch_pc.
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC & ~32'h3;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Decode-side output and FIFO control
  // --------------------------------------------------------------------------
`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_rsp_ok && fifo_empty && !RST;
`endif

  always_comb begin
    fifo_push = w_rsp_ok;
    // The flush wins over a pop in the redirect cycle.
    fifo_pop  = !fifo_empty && ir_ready && !redirect_valid;
    ir_valid  = !fifo_empty;
    ir        = NOP_INSTR;
    ir_pc     = '0;
    if (!fifo_empty) begin
      ir    = fifo_head.instr;
      ir_pc = fifo_head.pc;
    end
`ifdef IFQ_BYPASS_EN
    if (w_bypass) begin
      ir_valid = 1'b1;
      ir       = imem_rdata;
      ir_pc    = req_pc_q;
      // Consumed directly by decode, so it never occupies a slot.
      if (ir_ready) fifo_push = 1'b0;
    end
`endif
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (fifo_push),
    .data_i  ('{pc: req_pc_q, instr: imem_rdata}),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Fetch stage that sits directly upstream of the decoder and immediate generator in the Otter MCU. It owns the fetch PC and issues word reads to instruction memory, with one outstanding request. It buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch.

Parameters:
DEPTH, 2, FIFO entries (power of two, at least 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
imem_req  out  1  read request, held until granted
imem_addr  out  32  word address of the request; bits [1:0] always 0
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; at most one per grant, arrives 1 or more cycles after grant
imem_rdata  in  32  instruction word
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0
ir_valid  out  1  instruction available to decode
ir_ready  in  1  decode accepts when ir_valid && ir_ready
ir  out  32  instruction word; 32'h0000_0013 (NOP) when ir_valid=0
ir_pc  out  32  PC of ir; 0 when ir_valid=0

Behaviour:
- Reset (RST=1 at an edge): state=FETCH, fetch_pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir=NOP, ir_pc=0. Reset overrides redirect and all memory responses.
- Space rule: imem_req=1 only in FETCH, only when count+inflight < DEPTH, and not in the RST cycle. This guarantees no push into a full FIFO.
- FSM states: FETCH, WAIT_RSP, KILL.
  - FETCH: if imem_req && imem_gnt, then req_pc<=fetch_pc, fetch_pc+=4 (wraps at 2^32), go to WAIT_RSP.
  - WAIT_RSP: on imem_rvalid, push {req_pc, imem_rdata} and go to FETCH.
  - KILL: on imem_rvalid, discard the data and go to FETCH.
- Redirect, highest priority after reset:
  - FIFO flushed (count=0); fetch_pc<=redirect_pc&~3.
  - In FETCH with gnt in the same cycle: the granted request is stale, go to KILL.
  - In FETCH without gnt: the request is withdrawn and imem_addr changes next cycle. Otter imem tolerates this.
  - In WAIT_RSP with rvalid in the same cycle: drop the data, go to FETCH.
  - In WAIT_RSP without rvalid: go to KILL.
  - In KILL: stay in KILL.
  - A pop in the redirect cycle has no effect; the flush wins.
- While imem_req=1, imem_addr=fetch_pc and is stable until gnt or redirect.
- Pop when ir_valid && ir_ready. Simultaneous push and pop keeps count unchanged.
- Latency: rvalid to ir_valid is 1 cycle (registered FIFO output).
- Throughput: 1 instruction per 2 cycles with a 1-cycle memory.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty and rvalid is accepted in WAIT_RSP (no redirect), ir/ir_pc/ir_valid are driven combinationally from imem_rdata/req_pc in that same cycle.
  - If ir_ready=1, the word is consumed and not written.
  - Otherwise it is written and stays valid.
  - Latency is 0 cycles.
- Undefined: behaviour is as specified above, with 1-cycle latency and no combinational path from imem to ir.

Decomposition:
- Package ifq_pkg holds:
  - typedef enum logic [1:0] {FETCH, WAIT_RSP, KILL} ifq_state_t
  - localparam NOP_INSTR = 32'h0000_0013
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ifq_entry_t
- One sub-module, ifq_fifo: synchronous FIFO of ifq_entry_t with DEPTH parameter, push/pop/flush, count, and the same CLK/RST.
- The top level contains the FSM, the PC logic and the bypass.

Test Plan:
1. Reset, then a 1-cycle imem with gnt=1 and rvalid the next cycle, ir_ready=1.
   -> imem_addr sequence 0,4,8 every 2 cycles; ir_pc 0,4,8 with the matching words.
2. ir_ready=0 for 10 cycles.
   -> exactly DEPTH=2 words are queued and imem_req stays 0.
   -> Release: pops PC 0 then 4; fetch resumes at 8.
3. redirect_valid with redirect_pc=32'h0000_0103 in the same cycle as a gnt for PC 8.
   -> state KILL; the next rvalid is dropped; the next request is at 32'h100; the PC 8 word never appears on ir.
4. Redirect in the same cycle as rvalid in WAIT_RSP, with the FIFO holding 1 entry.
   -> FIFO empty next cycle, ir_valid=0, next imem_addr is the redirect target.
5. Assert RST mid-WAIT_RSP, then rvalid the next cycle.
   -> response ignored; ir_valid=0; the first request after reset is at RESET_PC.
6. IFQ_BYPASS_EN defined, FIFO empty, rvalid with rdata=32'h0050_0093, ir_ready=1.
   -> ir_valid=1 and ir=32'h0050_0093 in the same cycle; count stays 0.
